// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: FSM states and bus-timing constants shared by the I2C expander write sequencer
package i2c_seq_pkg;
   typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP, DONE} state_e;
   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;
   localparam logic ACK_BIT = 1'b0;
   localparam int CLK_DIV_MIN = 2;
endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: divides clk into quarter-bit ticks and tracks the quarter index within a bit
module i2c_quarter_timer
   import i2c_seq_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DIV_W   = 8
)(
   input  logic       clk,
   input  logic       start_and_reset_delayed,
   input  logic       clr,
   output logic       tick,
   output logic [1:0] quarter
);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [1:0]       qtr_q, qtr_d;
   assign tick    = !clr && cnt_q == DIV_W'(CLK_DIV - 1);
   assign quarter = qtr_q;
   always_comb begin
      cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
      qtr_d = clr ? Q0 : tick ? qtr_q + 2'd1 : qtr_q;
   end
   always_ff @(posedge clk or negedge start_and_reset_delayed)
      if (!start_and_reset_delayed) begin
         cnt_q <= '0;
         qtr_q <= Q0;
      end else begin
         cnt_q <= cnt_d;
         qtr_q <= qtr_d;
      end
endmodule

// File: rtl/i2c_expander_write_sequencer.sv
// i2c_expander_write_sequencer: round-robin shared I2C master issuing single-byte expander writes.
// Define I2C_NACK_RETRY_EN to retry a NACKed transaction once before reporting nack_err.
module i2c_expander_write_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int CLK_DIV = 4,
   parameter int DIV_W   = 8
)(
   input  logic                 clk,
   input  logic                 start_and_reset_delayed,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [7*NUM_REQ-1:0] req_adr,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic                 nack_err,
   output logic                 busy,
   output logic                 scl_oe,
   output logic                 sda_oe,
   input  logic                 sda_i
);
   localparam int PTR_W = $clog2(NUM_REQ);
   if (CLK_DIV < CLK_DIV_MIN || (CLK_DIV - 1) >= 2 ** DIV_W) begin : g_bad_div
      $error("CLK_DIV out of range for DIV_W");
   end
   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]   owner_q, owner_d, ptr_q, ptr_d, win, idx;
   logic [7:0]         shift_q, shift_d, data_q, data_d, sel_data;
   logic [6:0]         sel_adr;
   logic [2:0]         bit_cnt_q, bit_cnt_d;
   logic               nack_q, nack_d, scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic               sda_meta_q, sda_sync_q, found, tick, last;
   logic [1:0]         quarter;
`ifdef I2C_NACK_RETRY_EN
   logic [6:0]         adr_q, adr_d;
   logic               retry_q, retry_d;
`endif
   i2c_quarter_timer #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) u_timer (
      .clk                     (clk),
      .start_and_reset_delayed (start_and_reset_delayed),
      .clr                     (state_q == IDLE),
      .tick                    (tick),
      .quarter                 (quarter)
   );
   assign last     = tick && quarter == Q3;
   assign grant    = grant_q;
   assign busy     = state_q != IDLE;
   assign done     = state_q == DONE ? grant_q : '0;
   assign nack_err = state_q == DONE && nack_q;
   assign scl_oe   = scl_oe_q;
   assign sda_oe   = sda_oe_q;
   // Walk down from the farthest requester so the one at the pointer is assigned last and wins.
   always_comb begin
      win = ptr_q;
      idx = '0;
      found = 1'b0;
      sel_adr = '0;
      sel_data = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (req[idx]) begin
            win = idx;
            found = 1'b1;
         end
      end
      for (int k = 0; k < NUM_REQ; k++)
         if (int'(win) == k) begin
            sel_adr = req_adr[k*7 +: 7];
            sel_data = req_data[k*8 +: 8];
         end
   end
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d = ptr_q;
      shift_d = shift_q;
      data_d = data_q;
      bit_cnt_d = bit_cnt_q;
      nack_d = nack_q;
      scl_oe_d = 1'b0;
      sda_oe_d = 1'b0;
`ifdef I2C_NACK_RETRY_EN
      adr_d = adr_q;
      retry_d = retry_q;
`endif
      unique case (state_q)
         IDLE: if (found) begin
            state_d = START;
            grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
            owner_d = win;
            shift_d = {sel_adr, 1'b0};
            data_d = sel_data;
            nack_d = 1'b0;
`ifdef I2C_NACK_RETRY_EN
            adr_d = sel_adr;
            retry_d = 1'b0;
`endif
         end
         START: begin
            sda_oe_d = quarter != Q0;
            scl_oe_d = quarter == Q2 || quarter == Q3;
            if (last) state_d = ADDR;
         end
         ADDR, DATA: begin
            scl_oe_d = quarter == Q0 || quarter == Q1;
            sda_oe_d = ~shift_q[7];
            if (last) begin
               shift_d = {shift_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) state_d = state_q == ADDR ? ACK_A : ACK_D;
            end
         end
         ACK_A, ACK_D: begin
            scl_oe_d = quarter == Q0 || quarter == Q1;
            if (tick && quarter == Q2 && sda_sync_q != ACK_BIT) nack_d = 1'b1;
            if (last) begin
               state_d = (state_q == ACK_A && !nack_q) ? DATA : STOP;
               shift_d = data_q;
            end
         end
         STOP: begin
            scl_oe_d = quarter == Q0;
            sda_oe_d = quarter == Q0 || quarter == Q1;
`ifdef I2C_NACK_RETRY_EN
            if (last && nack_q && !retry_q) begin
               state_d = START;
               retry_d = 1'b1;
               nack_d = 1'b0;
               shift_d = {adr_q, 1'b0};
            end else if (last) state_d = DONE;
`else
            if (last) state_d = DONE;
`endif
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d = int'(owner_q) == NUM_REQ - 1 ? '0 : owner_q + 1'b1;
         end
      endcase
   end
   always_ff @(posedge clk or negedge start_and_reset_delayed)
      if (!start_and_reset_delayed) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q <= '0;
         shift_q <= '0;
         data_q <= '0;
         bit_cnt_q <= 3'd7;
         nack_q <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_oe_q <= 1'b0;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
`ifdef I2C_NACK_RETRY_EN
         adr_q <= '0;
         retry_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q <= ptr_d;
         shift_q <= shift_d;
         data_q <= data_d;
         bit_cnt_q <= bit_cnt_d;
         nack_q <= nack_d;
         scl_oe_q <= scl_oe_d;
         sda_oe_q <= sda_oe_d;
         sda_meta_q <= sda_i;
         sda_sync_q <= sda_meta_q;
`ifdef I2C_NACK_RETRY_EN
         adr_q <= adr_d;
         retry_q <= retry_d;
`endif
      end
endmodule

// File: tb/tb_i2c_expander_write_sequencer.sv
// tb_i2c_expander_write_sequencer: scoreboard bench with an ACKing expander slave model on the bus
module tb_i2c_expander_write_sequencer;
   localparam int CLK_DIV  = 4;
   localparam int LEN_FULL = 80 * CLK_DIV + 1;
   localparam int LEN_NACK = 44 * CLK_DIV + 1;
   typedef struct {logic [1:0] g; logic n; int len;} exp_t;
   logic        clk = 1'b0, rst_n = 1'b0, sda_i;
   logic [1:0]  req = '0, grant, done;
   logic [13:0] req_adr = '0;
   logic [15:0] req_data = '0;
   logic        nack_err, busy, scl_oe, sda_oe, slave_low = 1'b0;
   logic        scl_line, sda_line, prev_scl = 1'b1, prev_sda = 1'b1;
   logic [7:0]  shreg = '0;
   logic [7:0]  exp_bytes[$];
   exp_t        exp_done[$];
   exp_t        e;
   int          checks = 0, failures = 0, bitn = 0, rises = 0, starts = 0;
   int          busy_cnt = 0, done_seen = 0, nd = 0, ack_mode = 0;
   assign scl_line = ~scl_oe;
   assign sda_line = ~sda_oe & ~slave_low;
   assign sda_i    = sda_line;
   always #5 clk = ~clk;
   i2c_expander_write_sequencer #(.NUM_REQ(2), .CLK_DIV(CLK_DIV), .DIV_W(8)) dut (
      .clk(clk), .start_and_reset_delayed(rst_n), .req(req), .req_adr(req_adr),
      .req_data(req_data), .grant(grant), .done(done), .nack_err(nack_err), .busy(busy),
      .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic push_txn(input logic [1:0] g, input logic [6:0] a, input logic [7:0] d,
                           input logic n, input int len);
      exp_t x;
      exp_bytes.push_back({a, 1'b0});
      if (!n) exp_bytes.push_back(d);
      x.g = g; x.n = n; x.len = len;
      exp_done.push_back(x);
      nd++;
   endtask
   task automatic wait_done(input int budget);
      int n = 0;
      while (done_seen < nd && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_timeout", done_seen >= nd, 1);
   endtask
   task automatic wait_rises(input int target);
      int n = 0;
      while (rises < target && n < 1000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rise_timeout", rises >= target, 1);
   endtask
   // Bus monitor and slave: bytes are captured on SCL rise, ACK driven across the 9th SCL pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         bitn = 0;
         slave_low = 1'b0;
         prev_scl = 1'b1;
         prev_sda = 1'b1;
         busy_cnt = 0;
      end else begin
         busy_cnt = busy ? busy_cnt + 1 : 0;
         if (prev_scl && scl_line && prev_sda && !sda_line) begin
            starts++;
            bitn = 0;
         end
         if (!prev_scl && scl_line) begin
            rises++;
            shreg = {shreg[6:0], sda_line};
            bitn++;
            if (bitn == 8) begin
               if (exp_bytes.size() == 0) chk("byte_extra", {24'd0, shreg}, 32'hFFFF_FFFF);
               else chk("bus_byte", {24'd0, shreg}, {24'd0, exp_bytes.pop_front()});
            end
            if (bitn == 9) bitn = 0;
         end
         if (prev_scl && !scl_line)
            slave_low = bitn == 8 && (ack_mode == 0 || (ack_mode == 2 && starts > 1));
         if (done != 2'b00) begin
            done_seen++;
            if (exp_done.size() == 0) chk("done_extra", {30'd0, done}, 0);
            else begin
               e = exp_done.pop_front();
               chk("done_owner", {30'd0, done}, {30'd0, e.g});
               chk("nack_err", {31'd0, nack_err}, {31'd0, e.n});
               chk("busy_len", busy_cnt, e.len);
            end
         end
         if (nack_err && done == 2'b00) chk("nack_wo_done", 1, 0);
         prev_scl = scl_line;
         prev_sda = sda_line;
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_grant", {30'd0, grant}, 0);
      chk("rst_done", {30'd0, done}, 0);
      chk("rst_nack", {31'd0, nack_err}, 0);
      chk("rst_scl", {31'd0, scl_oe}, 0);
      chk("rst_sda", {31'd0, sda_oe}, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      ack_mode = 0;
      starts = 0;
      req_adr[6:0] = 7'h20;
      req_data[7:0] = 8'hA5;
      push_txn(2'b01, 7'h20, 8'hA5, 1'b0, LEN_FULL);
      req[0] = 1'b1;
      wait_done(1000);
      req[0] = 1'b0;
      chk("t1_starts", starts, 1);
      ack_mode = 1;
      req_adr[6:0] = 7'h55;
      req_data[7:0] = 8'h11;
`ifdef I2C_NACK_RETRY_EN
      exp_bytes.push_back(8'hAA);
      push_txn(2'b01, 7'h55, 8'h11, 1'b1, 88 * CLK_DIV + 1);
`else
      push_txn(2'b01, 7'h55, 8'h11, 1'b1, LEN_NACK);
`endif
      req[0] = 1'b1;
      wait_done(1000);
      req[0] = 1'b0;
      ack_mode = 0;
      req_adr[6:0] = 7'h10;
      req_data[7:0] = 8'hA5;
      push_txn(2'b01, 7'h10, 8'hA5, 1'b0, LEN_FULL);
      rises = 0;
      req[0] = 1'b1;
      wait_rises(3);
      req_data[7:0] = 8'h3C;
      wait_done(1000);
      req[0] = 1'b0;
      req_adr[6:0] = 7'h33;
      req_data[7:0] = 8'h77;
      exp_bytes.push_back(8'h66);
      rises = 0;
      req[0] = 1'b1;
      wait_rises(13);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req[0] = 1'b0;
      #1;
      chk("abort_scl", {31'd0, scl_oe}, 0);
      chk("abort_sda", {31'd0, sda_oe}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      chk("abort_grant", {30'd0, grant}, 0);
      chk("abort_done", {30'd0, done}, 0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      req_adr[13:7] = 7'h48;
      req_data[15:8] = 8'h0F;
      push_txn(2'b10, 7'h48, 8'h0F, 1'b0, LEN_FULL);
      req[1] = 1'b1;
      wait_done(1000);
      req[1] = 1'b0;
      req_adr = {7'h3F, 7'h21};
      req_data = {8'hC3, 8'h5A};
      for (int i = 0; i < 2; i++) begin
         push_txn(2'b01, 7'h21, 8'h5A, 1'b0, LEN_FULL);
         push_txn(2'b10, 7'h3F, 8'hC3, 1'b0, LEN_FULL);
      end
      req = 2'b11;
      wait_done(4000);
      req = 2'b00;
`ifdef I2C_NACK_RETRY_EN
      repeat (3) @(posedge clk);
      #1;
      ack_mode = 2;
      starts = 0;
      req_adr[6:0] = 7'h2A;
      req_data[7:0] = 8'h99;
      exp_bytes.push_back(8'h54);
      push_txn(2'b01, 7'h2A, 8'h99, 1'b0, 124 * CLK_DIV + 1);
      req[0] = 1'b1;
      wait_done(1500);
      req[0] = 1'b0;
      chk("retry_starts", starts, 2);
`endif
      repeat (20) @(posedge clk);
      #1;
      chk("bytes_left", exp_bytes.size(), 0);
      chk("dones_left", exp_done.size(), 0);
      chk("done_total", done_seen, nd);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
